// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-phase issue/writeback sequencer feeding a shared combinational ALU
`ifndef ALU_OPCODES
`define ALU_OPCODES
`define ADD   5'd1
`define SUB   5'd2
`define MUL   5'd3
`define DIV   5'd4
`define INC   5'd5
`define DEC   5'd6
`define AND   5'd7
`define OR    5'd8
`define XOR   5'd9
`define NOT   5'd10
`define ENCRY 5'd11
`define DECRY 5'd12
`define IMMED 5'd13
`endif
module alu_issue_ctrl #(
   parameter int          REG_ADDR_W   = 3,
   parameter logic [31:0] DIV_ZERO_VAL = 32'hFFFF_FFFF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [18:0]           instr,
   output logic [4:0]            alu_ctrl,
   output logic [31:0]           alu_in1,
   output logic [31:0]           alu_in2,
   input  logic [31:0]           alu_result,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [31:0]           wb_data,
   output logic                  illegal_op,
   output logic                  div_zero,
   input  logic [REG_ADDR_W-1:0] dbg_addr,
   output logic [31:0]           dbg_data
);
   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
   state_t state, state_nx;
   logic [18:0] ir;
   logic [31:0] rf [2**REG_ADDR_W];
   logic [31:0] res;
   logic [4:0]  op;
   logic        legal, dz;
   assign op = ir[18:14];
   assign legal = op inside {`ADD, `SUB, `MUL, `DIV, `INC, `DEC, `AND, `OR, `XOR,
                             `NOT, `ENCRY, `DECRY, `IMMED};
   assign dz = (alu_ctrl == `DIV) && (alu_in2 == 32'd0);
   assign wb_data = res;
   assign dbg_data = rf[dbg_addr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = (state == IDLE)   ? (instr_valid ? DECODE : IDLE) :
                 (state == DECODE) ? (legal ? EXEC : IDLE) :
                 (state == EXEC)   ? WB : IDLE;
   always_comb begin
      instr_ready = state == IDLE;
      illegal_op  = state == DECODE && !legal;
      div_zero    = state == EXEC && dz;
      wb_valid    = state == WB;
   end
   // operands are captured in DECODE, so a WB to rs1/rs2 of the same instruction cannot race
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ir       <= '0;
         alu_ctrl <= '0;
         alu_in1  <= '0;
         alu_in2  <= '0;
         res      <= '0;
         wb_addr  <= '0;
         for (int i = 0; i < 2**REG_ADDR_W; i++) rf[i] <= '0;
      end else begin
         if (instr_ready && instr_valid) ir <= instr;
         if (state == DECODE && legal) begin
            alu_ctrl <= op;
            alu_in1  <= rf[ir[10:8]];
            alu_in2  <= (op == `IMMED) ? {21'b0, ir[10:0]} : rf[ir[7:5]];
         end
         if (state == EXEC) begin
            res     <= dz ? DIV_ZERO_VAL : alu_result;
            wb_addr <= ir[13:11];
         end
         if (state == WB) rf[wb_addr] <= res;
      end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized bench with a behavioural ALU and an array-based regfile model
`ifndef ALU_OPCODES
`define ALU_OPCODES
`define ADD   5'd1
`define SUB   5'd2
`define MUL   5'd3
`define DIV   5'd4
`define INC   5'd5
`define DEC   5'd6
`define AND   5'd7
`define OR    5'd8
`define XOR   5'd9
`define NOT   5'd10
`define ENCRY 5'd11
`define DECRY 5'd12
`define IMMED 5'd13
`endif
module tb_alu_issue_ctrl;
   logic clk = 0, rst_n = 0, instr_valid = 0;
   logic instr_ready, wb_valid, illegal_op, div_zero;
   logic [18:0] instr = 0;
   logic [4:0] alu_ctrl;
   logic [31:0] alu_in1, alu_in2, alu_result, wb_data, dbg_data;
   logic [2:0] wb_addr, dbg_addr = 0;
   logic [31:0] model [8];
   int checks = 0, fails = 0;

   alu_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_result(alu_result), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .illegal_op(illegal_op), .div_zero(div_zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, b);
      case (op)
         `ADD:   return a + b;
         `SUB:   return a - b;
         `MUL:   return a * b;
         `DIV:   return (b == 0) ? 32'd0 : a / b;
         `INC:   return a + 1;
         `DEC:   return a - 1;
         `AND:   return a & b;
         `OR:    return a | b;
         `XOR:   return a ^ b;
         `NOT:   return ~a;
         `ENCRY: return a ^ 32'hA5A5_5A5A;
         `DECRY: return a ^ 32'hA5A5_5A5A;
         `IMMED: return b;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb alu_result = alu_f(alu_ctrl, alu_in1, alu_in2);

   function automatic bit is_legal(input logic [4:0] op);
      return op >= 5'd1 && op <= 5'd13;
   endfunction

   // issue one instruction from IDLE and follow it through every phase
   task automatic run(input logic [4:0] op, input logic [2:0] rd, rs1, rs2, input logic [10:0] imm);
      logic [18:0] w;
      logic [31:0] a, b, exp;
      int t;
      w = (op == `IMMED) ? {op, rd, imm} : {op, rd, rs1, rs2, imm[4:0]};
      a = model[w[10:8]];
      b = (op == `IMMED) ? {21'b0, w[10:0]} : model[w[7:5]];
      exp = (op == `DIV && b == 0) ? 32'hFFFF_FFFF : alu_f(op, a, b);
      instr = w;
      instr_valid = 1;
      t = 0;
      while (!instr_ready && t < 8) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (instr_ready !== 1'b1) begin
         fails++;
         $display("FAIL accept_timeout: instr_ready got %b required 1", instr_ready);
         instr_valid = 0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      instr_valid = 0;
      checks++;
      if (illegal_op !== !is_legal(op) || wb_valid !== 1'b0) begin
         fails++;
         $display("FAIL decode: illegal_op/wb_valid got %b%b required %b0", illegal_op, wb_valid, !is_legal(op));
      end
      @(negedge clk);
      if (!is_legal(op)) begin
         checks++;
         if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || illegal_op !== 1'b0) begin
            fails++;
            $display("FAIL illegal_return: ready/wb/ill got %b%b%b required 100", instr_ready, wb_valid, illegal_op);
         end
         return;
      end
      checks++;
      if (alu_ctrl !== op || alu_in1 !== a || alu_in2 !== b) begin
         fails++;
         $display("FAIL exec_operands: got %h %h %h required %h %h %h", alu_ctrl, alu_in1, alu_in2, op, a, b);
      end
      checks++;
      if (div_zero !== (op == `DIV && b == 0) || wb_valid !== 1'b0) begin
         fails++;
         $display("FAIL exec_flags: div_zero/wb_valid got %b%b required %b0", div_zero, wb_valid, op == `DIV && b == 0);
      end
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b1 || wb_addr !== rd || wb_data !== exp || div_zero !== 1'b0) begin
         fails++;
         $display("FAIL writeback: valid %b addr %0d data %h dz %b required 1 %0d %h 0", wb_valid, wb_addr, wb_data, div_zero, rd, exp);
      end
      model[rd] = exp;
      @(negedge clk);
      dbg_addr = rd;
      #1;
      checks++;
      if (dbg_data !== model[rd] || wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
         fails++;
         $display("FAIL regfile_update: R%0d got %h required %h (wb %b ready %b)", rd, dbg_data, model[rd], wb_valid, instr_ready);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (instr_ready !== 1 || wb_valid !== 0 || illegal_op !== 0 || div_zero !== 0 ||
          alu_ctrl !== 0 || alu_in1 !== 0 || alu_in2 !== 0 || wb_addr !== 0 || wb_data !== 0) begin
         fails++;
         $display("FAIL reset_outputs: rdy %b wb %b ill %b dz %b ctrl %h in1 %h in2 %h addr %h data %h",
                  instr_ready, wb_valid, illegal_op, div_zero, alu_ctrl, alu_in1, alu_in2, wb_addr, wb_data);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = i[2:0];
         #1;
         checks++;
         if (dbg_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_reg R%0d: got %h required 0", i, dbg_data);
         end
      end
   endtask

   task automatic test_immed;
      run(`IMMED, 3'd1, 0, 0, 11'h7FF);
      dbg_addr = 1;
      #1;
      checks++;
      if (dbg_data !== 32'h0000_07FF) begin
         fails++;
         $display("FAIL immed_r1: got %h required 000007ff", dbg_data);
      end
   endtask

   task automatic test_add_sub;
      run(`IMMED, 3'd1, 0, 0, 11'd5);
      run(`IMMED, 3'd2, 0, 0, 11'd7);
      run(`ADD, 3'd3, 3'd1, 3'd2, 0);
      run(`SUB, 3'd4, 3'd1, 3'd2, 0);
      dbg_addr = 3;
      #1;
      checks++;
      if (dbg_data !== 32'd12) begin
         fails++;
         $display("FAIL add_r3: got %h required 0000000c", dbg_data);
      end
      dbg_addr = 4;
      #1;
      checks++;
      if (dbg_data !== 32'hFFFF_FFFE) begin
         fails++;
         $display("FAIL sub_r4: got %h required fffffffe", dbg_data);
      end
   endtask

   task automatic test_div_zero;
      run(`IMMED, 3'd1, 0, 0, 11'd100);
      run(`IMMED, 3'd2, 0, 0, 11'd0);
      run(`DIV, 3'd5, 3'd1, 3'd2, 0);
      dbg_addr = 5;
      #1;
      checks++;
      if (dbg_data !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL div_zero_r5: got %h required ffffffff", dbg_data);
      end
      run(`IMMED, 3'd2, 0, 0, 11'd7);
      run(`DIV, 3'd6, 3'd1, 3'd2, 0);
   endtask

   task automatic test_illegal;
      logic [4:0] op;
      for (int k = 0; k < 4; k++) begin
         op = (k == 0) ? 5'd0 : 5'($urandom_range(14, 31));
         run(op, 3'($urandom), 3'($urandom), 3'($urandom), 11'($urandom));
         run(`ADD, 3'($urandom), 3'($urandom), 3'($urandom), 0);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = i[2:0];
         #1;
         checks++;
         if (dbg_data !== model[i]) begin
            fails++;
            $display("FAIL illegal_regs R%0d: got %h required %h", i, dbg_data, model[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [4:0] op;
      for (int k = 0; k < 60; k++) begin
         op = (k % 5 == 0) ? `IMMED : 5'($urandom_range(1, 13));
         run(op, 3'($urandom), 3'($urandom), 3'($urandom), 11'($urandom));
      end
   endtask

   task automatic test_back_to_back;
      int rdy = 0, wbs = 0;
      run(`IMMED, 3'd1, 0, 0, 11'd40);
      instr = {`INC, 3'd1, 3'd1, 3'd1, 5'd0};
      instr_valid = 1;
      for (int c = 0; c < 16; c++) begin
         rdy += int'(instr_ready);
         wbs += int'(wb_valid);
         @(negedge clk);
      end
      instr_valid = 0;
      model[1] = model[1] + 4;
      dbg_addr = 1;
      #1;
      checks++;
      if (rdy != 4 || wbs != 4) begin
         fails++;
         $display("FAIL back_to_back_rate: ready %0d wb %0d required 4 4", rdy, wbs);
      end
      checks++;
      if (dbg_data !== model[1]) begin
         fails++;
         $display("FAIL back_to_back_r1: got %h required %h", dbg_data, model[1]);
      end
   endtask

   task automatic test_reset_exec;
      int wbs = 0;
      instr = {`ADD, 3'd7, 3'd1, 3'd1, 5'd0};
      instr_valid = 1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 0;
      @(negedge clk);
      rst_n = 0;
      #1;
      for (int c = 0; c < 3; c++) begin
         wbs += int'(wb_valid);
         @(negedge clk);
      end
      checks++;
      if (wbs != 0 || alu_ctrl !== 0 || alu_in1 !== 0) begin
         fails++;
         $display("FAIL reset_exec: wb %0d ctrl %h in1 %h required 0 0 0", wbs, alu_ctrl, alu_in1);
      end
      rst_n = 1;
      for (int i = 0; i < 8; i++) model[i] = 0;
      test_reset;
      run(`IMMED, 3'd7, 0, 0, 11'h123);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model[i] = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1;
      test_reset;
      @(negedge clk);
      test_immed;
      test_add_sub;
      test_div_zero;
      test_illegal;
      test_random;
      test_back_to_back;
      test_reset_exec;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
